// File: rtl/register_file_if.sv
// Register-file port bundle: two combinational read ports and one clocked write port.
// The master drives indices and write data, and the slave returns read data.
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] ReadReg1;
  logic [ADDR_WIDTH-1:0] ReadReg2;
  logic [ADDR_WIDTH-1:0] WriteReg;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [DATA_WIDTH-1:0] ReadData1;
  logic [DATA_WIDTH-1:0] ReadData2;

  modport master (
    output RegWrite, ReadReg1, ReadReg2, WriteReg, WriteData,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, ReadReg1, ReadReg2, WriteReg, WriteData,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/register_file.sv
// General-purpose register file: 2**ADDR_WIDTH entries, two async reads, one sync write.
// Entry 0 is never written and always reads as zero.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  register_file_if.slave    bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];

  // Writes aimed at entry 0 are dropped here, so regs_q[0] stays at its reset value.
  always_comb begin
    regs_d = regs_q;
    if (bus.RegWrite && (bus.WriteReg != '0)) begin
      regs_d[bus.WriteReg] = bus.WriteData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // No write bypass: reads see the stored contents only.
  assign bus.ReadData1 = (bus.ReadReg1 == '0) ? '0 : regs_q[bus.ReadReg1];
  assign bus.ReadData2 = (bus.ReadReg2 == '0) ? '0 : regs_q[bus.ReadReg2];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, writes, reg0 protection, collision and async reset.
module tb_register_file;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rf_if ();

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rf_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic set_read(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    rf_if.ReadReg1 = r1;
    rf_if.ReadReg2 = r2;
    #1;
  endtask

  // Present a write on the falling edge, let one rising edge take it, then disable.
  task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    rf_if.RegWrite  = 1'b1;
    rf_if.WriteReg  = a;
    rf_if.WriteData = d;
    @(posedge clk);
    #1;
    rf_if.RegWrite  = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst             = 1'b1;
    rf_if.RegWrite  = 1'b0;
    rf_if.ReadReg1  = '0;
    rf_if.ReadReg2  = '0;
    rf_if.WriteReg  = '0;
    rf_if.WriteData = '0;

    // Reset state, including a write attempted while reset is held
    rf_if.RegWrite  = 1'b1;
    rf_if.WriteReg  = 5'd5;
    rf_if.WriteData = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    set_read(5'd5, 5'd31);
    check("rst_hold_r5", rf_if.ReadData1, 32'h0);
    check("rst_hold_r31", rf_if.ReadData2, 32'h0);
    @(negedge clk);
    rf_if.RegWrite = 1'b0;
    rst = 1'b0;
    set_read(5'd0, 5'd5);
    check("reset_r0", rf_if.ReadData1, 32'h0);
    check("reset_r5", rf_if.ReadData2, 32'h0);
    set_read(5'd31, 5'd31);
    check("reset_r31", rf_if.ReadData1, 32'h0);

    // Basic writes
    write_reg(5'd5, 32'hABCD1234);
    set_read(5'd5, 5'd0);
    check("wr5_rd1", rf_if.ReadData1, 32'hABCD1234);
    check("wr5_rd2_r0", rf_if.ReadData2, 32'h0);

    write_reg(5'd10, 32'h12345678);
    set_read(5'd10, 5'd5);
    check("wr10_rd1", rf_if.ReadData1, 32'h12345678);
    check("wr10_rd2_r5", rf_if.ReadData2, 32'hABCD1234);

    write_reg(5'd31, 32'hA5A5F00F);
    set_read(5'd31, 5'd10);
    check("wr31_rd1", rf_if.ReadData1, 32'hA5A5F00F);
    check("wr31_rd2_r10", rf_if.ReadData2, 32'h12345678);

    // Overwrite, then a disabled write must change nothing
    write_reg(5'd5, 32'h87654321);
    set_read(5'd5, 5'd10);
    check("ovr5_rd1", rf_if.ReadData1, 32'h87654321);
    check("ovr5_rd2", rf_if.ReadData2, 32'h12345678);
    @(negedge clk);
    rf_if.RegWrite  = 1'b0;
    rf_if.WriteReg  = 5'd5;
    rf_if.WriteData = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    set_read(5'd5, 5'd10);
    check("nowe_r5", rf_if.ReadData1, 32'h87654321);
    check("nowe_r10", rf_if.ReadData2, 32'h12345678);

    // Register 0 ignores writes
    write_reg(5'd0, 32'hFFFFFFFF);
    set_read(5'd0, 5'd0);
    check("r0_rd1", rf_if.ReadData1, 32'h0);
    check("r0_rd2", rf_if.ReadData2, 32'h0);

    // Collision: both ports on reg7 while it is written, no bypass
    write_reg(5'd7, 32'h11112222);
    @(negedge clk);
    set_read(5'd7, 5'd7);
    rf_if.RegWrite  = 1'b1;
    rf_if.WriteReg  = 5'd7;
    rf_if.WriteData = 32'h55AA55AA;
    #1;
    check("coll_pre_rd1", rf_if.ReadData1, 32'h11112222);
    check("coll_pre_rd2", rf_if.ReadData2, 32'h11112222);
    @(posedge clk);
    #1;
    rf_if.RegWrite = 1'b0;
    check("coll_post_rd1", rf_if.ReadData1, 32'h55AA55AA);
    check("coll_post_rd2", rf_if.ReadData2, 32'h55AA55AA);

    // Asynchronous reset between edges while a write is pending
    @(negedge clk);
    rf_if.RegWrite  = 1'b1;
    rf_if.WriteReg  = 5'd10;
    rf_if.WriteData = 32'h0BADF00D;
    set_read(5'd10, 5'd31);
    check("pre_arst_r10", rf_if.ReadData1, 32'h12345678);
    #1;
    rst = 1'b1;
    #1;
    check("arst_r10", rf_if.ReadData1, 32'h0);
    check("arst_r31", rf_if.ReadData2, 32'h0);
    @(posedge clk);
    #1;
    check("arst_edge_r10", rf_if.ReadData1, 32'h0);
    @(negedge clk);
    rf_if.RegWrite = 1'b0;
    rst = 1'b0;
    set_read(5'd10, 5'd7);
    check("post_arst_r10", rf_if.ReadData1, 32'h0);
    check("post_arst_r7", rf_if.ReadData2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
